// File: rtl/elastic_fifo.sv
// rtl/elastic_fifo.sv - DEPTH-entry elastic buffer on a valid/ready stream, all outputs registered
// Optional synchronous flush port enabled by ELASTIC_FIFO_FLUSH_EN.
module elastic_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int AF_THRESH = DEPTH - 1
) (
   input  logic                         clk,
   input  logic                         rstn,
`ifdef ELASTIC_FIFO_FLUSH_EN
   input  logic                         flush,
`endif
   input  logic                         s_valid,
   input  logic [WIDTH-1:0]             s_data,
   output logic                         s_ready,
   output logic                         m_valid,
   output logic [WIDTH-1:0]             m_data,
   input  logic                         m_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         almost_full
);

   localparam int CW    = $clog2(DEPTH + 1);
   localparam int RAM_D = DEPTH - 1;
   localparam int PW    = (RAM_D > 1) ? $clog2(RAM_D) : 1;

   logic                r_s_ready;
   logic                r_m_valid;
   logic                r_af;
   logic [WIDTH-1:0]    r_m_data;
   logic [CW-1:0]       r_count;
   logic [PW-1:0]       r_rptr;
   logic [PW-1:0]       r_wptr;
   logic [WIDTH-1:0]    r_mem [2**PW];

   logic                w_push;
   logic                w_pop;
   logic                w_flush;
   logic [CW-1:0]       w_stored;
   logic                w_stored_any;
   logic                w_out_free;
   logic                w_load_ram;
   logic                w_load_in;
   logic                w_write_ram;
   logic [CW-1:0]       w_count_next;

`ifdef ELASTIC_FIFO_FLUSH_EN
   assign w_flush = flush;
`else
   assign w_flush = 1'b0;
`endif

   assign w_push       = s_valid & r_s_ready;
   assign w_pop        = r_m_valid & m_ready;
   // Entries behind the output register live in the circular RAM.
   assign w_stored     = r_count - CW'(r_m_valid);
   assign w_stored_any = (w_stored != '0);
   assign w_out_free   = ~r_m_valid | w_pop;
   assign w_load_ram   = w_out_free & w_stored_any;
   assign w_load_in    = w_out_free & ~w_stored_any & w_push;
   assign w_write_ram  = w_push & ~w_load_in;
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RAM_D - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (!rstn || w_flush) begin
         r_m_valid <= 1'b0;
         r_s_ready <= 1'b1;
         r_count   <= '0;
         r_af      <= 1'b0;
         r_rptr    <= '0;
         r_wptr    <= '0;
      end else begin
         r_count   <= w_count_next;
         r_s_ready <= (w_count_next < CW'(DEPTH));
         r_af      <= (w_count_next >= CW'(AF_THRESH));
         if (w_out_free)
            r_m_valid <= w_load_ram | w_load_in;
         if (w_load_ram)
            r_rptr <= ptr_inc(r_rptr);
         if (w_write_ram)
            r_wptr <= ptr_inc(r_wptr);
      end
   end

   // Datapath is left unreset; m_data is only meaningful while m_valid is high.
   always_ff @(posedge clk) begin
      if (rstn && !w_flush) begin
         if (w_load_ram)
            r_m_data <= r_mem[r_rptr];
         else if (w_load_in)
            r_m_data <= s_data;
         if (w_write_ram)
            r_mem[r_wptr] <= s_data;
      end
   end

   assign s_ready     = r_s_ready;
   assign m_valid     = r_m_valid;
   assign m_data      = r_m_data;
   assign count       = r_count;
   assign almost_full = r_af;

endmodule

// File: doc/elastic_fifo.md
Name: elastic_fifo

Overview:
- Parametrised successor to the team's 2-entry skid buffer: a DEPTH-entry elastic buffer on a valid/ready stream.
- All outputs are registered: m_valid, m_data, s_ready, count and almost_full. There is no combinational path from input ports to output ports.
- Inserted between pipeline stages to break long ready/valid timing paths and to absorb burst backpressure.
- Also exposes its occupancy and an almost-full flag for upstream flow control.

Parameters:
- WIDTH, 8, data width in bits.
- DEPTH, 4, total entries including the output register; legal range 2..256.
- AF_THRESH, DEPTH-1, almost_full asserts when occupancy >= AF_THRESH; legal range 1..DEPTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rstn  input  1  synchronous, active-low reset.
- s_valid  input  1  upstream data valid.
- s_data  input  WIDTH  upstream data.
- s_ready  output  1  buffer can accept; registered.
- m_valid  output  1  downstream data valid; registered.
- m_data  output  WIDTH  downstream data; registered.
- m_ready  input  1  downstream accepts.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH; registered.
- almost_full  output  1  registered flag, equal to (count >= AF_THRESH).

Behaviour:
- Handshake definitions:
  - push = s_valid & s_ready.
  - pop = m_valid & m_ready.
  - A transfer occurs only on the cycle both handshake signals are high.
- Reset (rstn=0 at a clock edge), highest priority:
  - m_valid=0, s_ready=1, count=0, almost_full=0 (when AF_THRESH>=1).
  - m_data is not reset and must not be checked while m_valid=0.
- Storage:
  - Output register holds the head entry; DEPTH-1 entries sit in a circular RAM behind it.
  - Read and write pointers wrap modulo DEPTH-1.
- Occupancy:
  - count_next = count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
- Latency:
  - A word pushed into an empty buffer at edge N appears with m_valid=1 after edge N.
  - Minimum latency is 1 cycle; there is no combinational bypass.
- Output loading:
  - When the output register is empty, or popped in the current cycle, it loads the oldest stored entry if one exists.
  - Otherwise it loads the pushed word if a push occurs.
  - Otherwise m_valid goes to 0.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Output stability: while m_valid=1 and m_ready=0, m_data and m_valid hold.
- s_ready:
  - s_ready is registered as (count_next < DEPTH).
  - When count=DEPTH, s_ready=0 and a simultaneous pop raises s_ready one cycle later.
  - A push with s_ready=0 is ignored.
- Throughput: sustained 1 word/cycle when m_ready is held at 1, for all DEPTH >= 2.
- Full and empty conditions:
  - Full: count=DEPTH implies s_ready=0.
  - Empty: count=0 implies m_valid=0.
  - m_valid equals (count != 0) at all times.
- X handling: s_data is ignored when s_valid=0; m_ready is ignored when m_valid=0.

Optional Feature:
- Macro: ELASTIC_FIFO_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - flush=1 at an edge (with rstn=1) sets count=0, m_valid=0, s_ready=1, almost_full=0, and resets the pointers.
  - Any push or pop in that cycle is discarded.
  - Flush has priority over push and pop; reset has priority over flush.
- When undefined: the flush port does not exist and there is no flush logic.

Test Plan:
- Reset and fill:
  - Stimulus: DEPTH=4, AF_THRESH=3; after reset, push 0x11, 0x22, 0x33, 0x44 with m_ready=0.
  - Required: count goes 1, 2, 3, 4; almost_full rises after the third push; s_ready=0 after the fourth; m_data=0x11 is held.
- Drain order:
  - Stimulus: from full, m_ready=1 for 4 cycles.
  - Required: outputs 0x11, 0x22, 0x33, 0x44 in order; then m_valid=0, count=0, s_ready=1.
- Streaming:
  - Stimulus: s_valid=1 and m_ready=1 continuously, data counting 0..99.
  - Required: m_valid=1 from cycle 1 onward, m_data increments by 1 each cycle, count stays 1.
- Full with simultaneous pop:
  - Stimulus: count=4, s_valid=1, m_ready=1 for one cycle.
  - Required: push is ignored in that cycle; count=3 and s_ready=1 the next cycle; no word lost.
- Random stall:
  - Stimulus: random s_valid and m_ready (50%) for 10000 cycles with DEPTH in {2, 5, 16}.
  - Required: scoreboard order matches; m_data stable under stall; count equals the model.
- Flush (ELASTIC_FIFO_FLUSH_EN defined):
  - Stimulus: count=3, assert flush together with s_valid=1.
  - Required: next cycle count=0, m_valid=0, s_ready=1; the pushed word never appears at the output.
